// File: rtl/udp_tx_payload_buf.sv
// rtl/udp_tx_payload_buf.sv - Ping-pong payload buffer presenting committed UDP payloads to the GMII sender
// Optional feature: define UDP_TX_PAD_EN to zero-pad payloads shorter than 18 bytes.
module udp_tx_payload_buf #(
    parameter int SLOT_WORDS = 256,
    parameter int SLOT0_BASE = 1,
    parameter int SLOT1_BASE = 257
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_last,
    input  logic [2:0]  wr_bytes,
    input  logic [8:0]  ram_rd_addr,
    output logic [31:0] datain,
    output logic        pkt_ready,
    output logic [8:0]  pkt_base,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    input  logic        pkt_done,
    output logic        ovf_err
);
    typedef enum logic [1:0] {EMPTY, FILL, FULL, SEND} slot_state_t;

    localparam logic [8:0]  LAST_IDX     = 9'(SLOT_WORDS - 1);
    localparam logic [8:0]  BASE0        = 9'(SLOT0_BASE);
    localparam logic [8:0]  BASE1        = 9'(SLOT1_BASE);
    localparam logic [15:0] FULL_BYTES   = 16'(4 * SLOT_WORDS);
    localparam logic [8:0]  PAD_LAST_IDX = 9'd4;
`ifdef UDP_TX_PAD_EN
    localparam logic [15:0] MIN_BYTES    = 16'd18;
`endif

    slot_state_t state_q [2];
    slot_state_t state_d [2];
    logic        wsel_q, wsel_d;
    logic        rsel_q, rsel_d;
    logic [8:0]  wcnt_q, wcnt_d;
    logic        discard_q, discard_d;
    logic        pad_q, pad_d;
    logic [15:0] bytes_q [2];

    logic        accept;
    logic        commit;
    logic        present;
    logic        store_len;
    logic        set_ovf;
    logic [15:0] store_bytes;
    logic [15:0] word_bytes;
    logic [15:0] payload;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem [512];
`ifdef UDP_TX_PAD_EN
    logic [31:0] keep_mask;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            wcnt_q     <= '0;
            discard_q  <= 1'b0;
            pad_q      <= 1'b0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            wcnt_q     <= wcnt_d;
            discard_q  <= discard_d;
            pad_q      <= pad_d;
        end
    end

    always_comb begin
        state_d[0]  = state_q[0];
        state_d[1]  = state_q[1];
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        wcnt_d      = wcnt_q;
        discard_d   = discard_q;
        pad_d       = pad_q;
        present     = 1'b0;
        store_len   = 1'b0;
        store_bytes = payload;
        set_ovf     = 1'b0;
        commit      = 1'b0;

        if (pkt_ready && pkt_done) begin
            state_d[rsel_q] = EMPTY;
            rsel_d          = ~rsel_q;
        end else if (state_q[rsel_q] == FULL) begin
            state_d[rsel_q] = SEND;
            present         = 1'b1;
        end

        if (pad_q) begin
            if (wcnt_q == PAD_LAST_IDX) begin
                commit = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 9'd1;
            end
        end else if (accept && discard_q) begin
            if (wr_last) begin
                discard_d = 1'b0;
            end
        end else if (accept) begin
            state_d[wsel_q] = FILL;
            wcnt_d          = wcnt_q + 9'd1;
            if (wr_last) begin
                store_len = 1'b1;
`ifdef UDP_TX_PAD_EN
                if (payload < MIN_BYTES) begin
                    store_bytes = MIN_BYTES;
                    if (wcnt_q == PAD_LAST_IDX) begin
                        commit = 1'b1;
                    end else begin
                        pad_d = 1'b1;
                    end
                end else begin
                    commit = 1'b1;
                end
`else
                commit = 1'b1;
`endif
            end else if (wcnt_q == LAST_IDX) begin
                // Slot is full: close it as a 4-byte-last packet and drop the rest of the producer's packet.
                store_len   = 1'b1;
                store_bytes = FULL_BYTES;
                set_ovf     = 1'b1;
                discard_d   = 1'b1;
                commit      = 1'b1;
            end
        end

        // Placed after the release so a commit into the released slot wins.
        if (commit) begin
            state_d[wsel_q] = FULL;
            wsel_d          = ~wsel_q;
            wcnt_d          = '0;
            pad_d           = 1'b0;
        end
    end

    always_comb begin
        wr_ready   = discard_q || (!pad_q && (state_q[wsel_q] == EMPTY || state_q[wsel_q] == FILL));
        pkt_ready  = (state_q[rsel_q] == SEND);
        accept     = wr_valid && wr_ready;
        word_bytes = (wr_bytes == 3'd0 || wr_bytes > 3'd4) ? 16'd4 : {13'd0, wr_bytes};
        payload    = {5'd0, wcnt_q, 2'b00} + word_bytes;
        // 9-bit address arithmetic wraps, so the top slot word can land at address 0.
        mem_waddr  = (wsel_q ? BASE1 : BASE0) + wcnt_q;
        mem_we     = pad_q || (accept && !discard_q);
        mem_wdata  = pad_q ? 32'd0 : wr_data;
`ifdef UDP_TX_PAD_EN
        case (word_bytes[2:0])
            3'd1:    keep_mask = 32'hFF00_0000;
            3'd2:    keep_mask = 32'hFFFF_0000;
            3'd3:    keep_mask = 32'hFFFF_FF00;
            default: keep_mask = 32'hFFFF_FFFF;
        endcase
        if (!pad_q && wr_last && payload < MIN_BYTES) begin
            mem_wdata = wr_data & keep_mask;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_q[0]      <= '0;
            bytes_q[1]      <= '0;
            pkt_base        <= BASE0;
            tx_data_length  <= 16'd8;
            tx_total_length <= 16'd28;
            ovf_err         <= 1'b0;
            datain          <= '0;
        end else begin
            if (store_len) begin
                bytes_q[wsel_q] <= store_bytes;
            end
            if (present) begin
                pkt_base        <= rsel_q ? BASE1 : BASE0;
                tx_data_length  <= bytes_q[rsel_q] + 16'd8;
                tx_total_length <= bytes_q[rsel_q] + 16'd28;
            end
            if (set_ovf) begin
                ovf_err <= 1'b1;
            end
            datain <= mem[ram_rd_addr];
        end
    end
endmodule
